// File: rtl/mips_muldiv_unit_if.sv
// rtl/mips_muldiv_unit_if.sv - EX-stage request / HI-LO result bundle for the mul/div unit
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, wdata,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI/LO
// One shift-add or restoring-subtract step per cycle, signs applied in a final FIX cycle.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic                clk_20,
  input logic                rst_n,
  mips_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               dbz_r;

  // Operand conditioning at accept: signed ops work on magnitudes.
  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  assign in_signed = ~bus.op[0];
  assign a_neg     = in_signed & bus.src_a[WIDTH-1];
  assign b_neg     = in_signed & bus.src_b[WIDTH-1];
  assign in_mag_a  = a_neg ? -bus.src_a : bus.src_a;
  assign in_mag_b  = b_neg ? -bus.src_b : bus.src_b;

  // Multiply step: add multiplicand into the upper half when the current LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: shift next dividend bit into the WIDTH+1-bit partial remainder, subtract if it fits.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   quo_next;

  assign div_shift    = {rem, quo[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, mag_b};
  assign div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
  assign quo_next     = {quo[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_rem ? -rem : rem;

  always_ff @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      a_raw   <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      dbz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          if (bus.start) begin
            state   <= CALC;
            cnt     <= '0;
            busy_r  <= 1'b1;
            dbz_r   <= 1'b0;
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (bus.src_b == '0);
            a_raw   <= bus.src_a;
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            acc     <= {{WIDTH{1'b0}}, in_mag_b};
            rem     <= '0;
            quo     <= in_mag_a;
          end
        end
        CALC: begin
          if (is_div) begin
            rem <= div_rem_next;
            quo <= quo_next;
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (is_div) begin
            if (b_zero) begin
              hi_r  <= a_raw;
              lo_r  <= '1;
              dbz_r <= 1'b1;
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - directed bench with an arithmetic reference model for mips_muldiv_unit
module tb_mips_muldiv_unit;
  logic clk_20 = 1'b0;
  logic rst_n  = 1'b0;

  mips_muldiv_unit_if #(.WIDTH(32)) bus ();

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk_20 (clk_20),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_20 = ~clk_20;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} straight from the arithmetic definition.
  function automatic logic [64:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     q;
    longint     r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        return {1'b0, p};
      end
      2'b10: begin
        if (b == 32'b0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'b0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Cycle-level expectation: an accepted op completes 33 edges later.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dbz  = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  int          m_cnt  = 0;
  logic [64:0] m_pend = '0;

  always @(posedge clk_20 or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      m_cnt  <= m_cnt + 1;
      m_done <= 1'b0;
      if (m_cnt == 32) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_dbz  <= m_pend[64];
        m_hi   <= m_pend[63:32];
        m_lo   <= m_pend[31:0];
      end
    end else begin
      m_done <= 1'b0;
      if (bus.mthi) m_hi <= bus.wdata;
      if (bus.mtlo) m_lo <= bus.wdata;
      if (bus.start) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_dbz  <= 1'b0;
        m_pend <= model_result(bus.op, bus.src_a, bus.src_b);
      end
    end
  end

  always @(negedge clk_20) begin
    if (check_en) begin
      chk("cyc_busy", 65'(bus.busy), 65'(m_busy));
      chk("cyc_done", 65'(bus.done), 65'(m_done));
      chk("cyc_dbz",  65'(bus.div_by_zero), 65'(m_dbz));
      chk("cyc_hi",   65'(bus.hi), 65'(m_hi));
      chk("cyc_lo",   65'(bus.lo), 65'(m_lo));
    end
  end

  task automatic issue_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_20);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk_20);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc);
    int guard;
    busy_cyc = 0;
    guard    = 0;
    while (!bus.done && guard < 60) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk_20);
      guard++;
    end
    chk("done_timeout", 65'(bus.done), 65'd1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int bc;
    issue_op(o, a, b);
    wait_done(bc);
    chk({nm, "_hi"}, 65'(bus.hi), 65'(exp_hi));
    chk({nm, "_lo"}, 65'(bus.lo), 65'(exp_lo));
    chk({nm, "_dbz"}, 65'(bus.div_by_zero), 65'(exp_dbz));
    chk({nm, "_busycyc"}, 65'(bc), 65'd33);
    @(negedge clk_20);
    chk({nm, "_done_1cyc"}, 65'(bus.done), 65'd0);
  endtask

  initial begin
    int bc;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    chk("model_multu_max", model_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    chk("model_div_ovf",   model_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'h0, 32'h8000_0000});
    chk("model_div_neg",   model_result(2'b10, 32'hFFFF_FFF9, 32'd2),         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    repeat (3) @(negedge clk_20);
    chk("rst_busy", 65'(bus.busy), 65'd0);
    chk("rst_done", 65'(bus.done), 65'd0);
    chk("rst_hi",   65'(bus.hi), 65'd0);
    chk("rst_lo",   65'(bus.lo), 65'd0);
    chk("rst_dbz",  65'(bus.div_by_zero), 65'd0);
    check_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk_20);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0);
    run_op("div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7d2",  2'b11, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
    run_op("div_7dm2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'b11, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 1'b1);

    issue_op(2'b01, 32'd2, 32'd3);
    chk("dbz_clr_on_accept", 65'(bus.div_by_zero), 65'd0);
    // Start and mthi while busy must both be dropped.
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.src_a = 32'd9;
    bus.src_b = 32'd3;
    bus.mthi  = 1'b1;
    bus.wdata = 32'hAA;
    @(negedge clk_20);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    wait_done(bc);
    chk("busy_ign_hi", 65'(bus.hi), 65'd0);
    chk("busy_ign_lo", 65'(bus.lo), 65'd6);
    @(negedge clk_20);
    chk("busy_ign_nostart", 65'(bus.busy), 65'd0);

    bus.mtlo  = 1'b1;
    bus.wdata = 32'h55;
    @(negedge clk_20);
    bus.mtlo  = 1'b0;
    chk("mtlo_idle", 65'(bus.lo), 65'h55);
    chk("mtlo_keep_hi", 65'(bus.hi), 65'd0);

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk_20);
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    chk("mt_both_hi", 65'(bus.hi), 65'hDEAD_BEEF);
    chk("mt_both_lo", 65'(bus.lo), 65'hDEAD_BEEF);

    // mthi on the accept edge lands first, then the product overwrites it.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.src_a = 32'd4;
    bus.src_b = 32'd4;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h77;
    @(negedge clk_20);
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("mthi_with_start_hi", 65'(bus.hi), 65'h77);
    chk("mthi_with_start_busy", 65'(bus.busy), 65'd1);
    wait_done(bc);
    chk("mthi_with_start_res_hi", 65'(bus.hi), 65'd0);
    chk("mthi_with_start_res_lo", 65'(bus.lo), 65'd16);

    issue_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk_20);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 65'(bus.busy), 65'd0);
    chk("midrst_done", 65'(bus.done), 65'd0);
    chk("midrst_hi",   65'(bus.hi), 65'd0);
    chk("midrst_lo",   65'(bus.lo), 65'd0);
    repeat (2) @(negedge clk_20);
    rst_n = 1'b1;
    @(negedge clk_20);
    run_op("post_rst_multu", 2'b01, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);

    repeat (2) @(negedge clk_20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
